mdu_arbiter: RTL and testbench

Controller that shares the single multiply/divide unit (MDU) between two requesters: port 0 (E-stage pipeline) and port 1 (secondary master, e.g. a debug/coprocessor path). It arbitrates round-robin, serializes one MDU operation at a time, drives the MDU control/operand/start lines, waits out the MDU busy window, and returns a response with handshake. It sits between the requesters and the MDU; the MDU's own interrupt-hold input is tied low at top level.

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_arbiter_if.sv | 24 ++
 rtl/mdu_rr_pick.sv | 19 +
 rtl/mdu_arbiter.sv | 138 +++++++++++++
 tb/tb_mdu_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU arbiter: op codes, FSM states, request payload.
package mdu_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] MDU_IDLE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
    } mdu_req_t;

    // Ops that start a multi-cycle MDU computation.
    function automatic logic is_mdu_long(input logic [OP_W-1:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
        return (op >= OP_MFHI) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arbiter_if.sv
// One requester port of the MDU arbiter: request handshake plus response handshake.
interface mdu_arbiter_if;
    import mdu_pkg::*;

    logic            valid;
    logic [OP_W-1:0] op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic            ready;
    logic            resp_valid;
    logic [DW-1:0]   resp_data;
    logic            resp_ready;

    modport master (
        output valid, op, a, b, resp_ready,
        input  ready, resp_valid, resp_data
    );

    modport slave (
        input  valid, op, a, b, resp_ready,
        output ready, resp_valid, resp_data
    );

endinterface

// File: rtl/mdu_rr_pick.sv
// Two-way round-robin picker: on contention the port not granted last time wins.
module mdu_rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = 1'b0;
        if (&valid) begin
            grant_id = ~last;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
        grant = {grant_id, ~grant_id} & {2{|valid}};
    end

endmodule

// File: rtl/mdu_arbiter.sv
// Shares one multiply/divide unit between two requesters, one operation at a time.
module mdu_arbiter
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    mdu_arbiter_if.slave    p0,
    mdu_arbiter_if.slave    p1,
    output logic [OP_W-1:0] mdu_ctrl,
    output logic [DW-1:0]   mdu_a,
    output logic [DW-1:0]   mdu_b,
    output logic            mdu_start,
    input  logic            mdu_busy,
    input  logic [DW-1:0]   mdu_hilo,
    output logic            arb_busy
);

    state_t        state;
    state_t        state_nxt;
    logic          last;
    logic          owner;
    mdu_req_t      req_q;
    logic [DW-1:0] resp_q;

    logic [1:0]    req_valid;
    logic [1:0]    grant;
    logic          grant_id;
    mdu_req_t      req0;
    mdu_req_t      req1;
    logic          flush_own;
    logic          owner_resp_ready;
    logic          is_read;
    logic [1:0]    ready;
    logic [1:0]    resp_valid;

    assign req_valid        = {p1.valid, p0.valid};
    assign req0             = {p0.op, p0.a, p0.b};
    assign req1             = {p1.op, p1.a, p1.b};
    // Flush only cancels port-0 work; port 1 is never affected.
    assign flush_own        = flush && !owner;
    assign owner_resp_ready = owner ? p1.resp_ready : p0.resp_ready;
    assign is_read          = (req_q.op == OP_MFHI) || (req_q.op == OP_MFLO);

    mdu_rr_pick u_pick (
        .valid    (req_valid),
        .last     (last),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (|grant) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (flush_own) begin
                    state_nxt = S_IDLE;
                end else if (!mdu_busy) begin
                    state_nxt = is_mdu_long(req_q.op) ? S_WAIT : S_DONE;
                end
            end
            // Once the MDU has the op it is committed, so flush is ignored here.
            S_WAIT: begin
                if (!mdu_busy) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (flush_own || owner_resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch on grant, response capture for HI/LO reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last   <= 1'b1;
            owner  <= 1'b0;
            req_q  <= '0;
            resp_q <= '0;
        end else begin
            if ((state == S_IDLE) && (|grant)) begin
                owner  <= grant_id;
                last   <= grant_id;
                req_q  <= grant_id ? req1 : req0;
                resp_q <= '0;
            end
            if ((state == S_ISSUE) && !flush_own && !mdu_busy && is_read) begin
                resp_q <= mdu_hilo;
            end
        end
    end

    always_comb begin
        ready      = 2'b00;
        resp_valid = 2'b00;
        mdu_ctrl   = MDU_IDLE;
        mdu_a      = '0;
        mdu_b      = '0;
        mdu_start  = 1'b0;
        arb_busy   = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (reset) ready = grant;
            end
            S_ISSUE: begin
                if (!flush_own && !mdu_busy) begin
                    mdu_ctrl  = is_mdu_op(req_q.op) ? req_q.op : MDU_IDLE;
                    mdu_a     = req_q.a;
                    mdu_b     = req_q.b;
                    mdu_start = is_mdu_long(req_q.op);
                end
            end
            S_DONE: begin
                if (!flush_own) resp_valid[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    assign p0.ready      = ready[0];
    assign p1.ready      = ready[1];
    assign p0.resp_valid = resp_valid[0];
    assign p1.resp_valid = resp_valid[1];
    assign p0.resp_data  = resp_valid[0] ? resp_q : '0;
    assign p1.resp_data  = resp_valid[1] ? resp_q : '0;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a small behavioural MDU (5-cycle mult, 10-cycle div).
module tb_mdu_arbiter;
    import mdu_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic [OP_W-1:0] mdu_ctrl;
    logic [DW-1:0]   mdu_a;
    logic [DW-1:0]   mdu_b;
    logic            mdu_start;
    logic            mdu_busy;
    logic [DW-1:0]   mdu_hilo;
    logic            arb_busy;

    int total = 0;
    int bad   = 0;

    mdu_arbiter_if p0if ();
    mdu_arbiter_if p1if ();

    mdu_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .p0        (p0if),
        .p1        (p1if),
        .mdu_ctrl  (mdu_ctrl),
        .mdu_a     (mdu_a),
        .mdu_b     (mdu_b),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy),
        .mdu_hilo  (mdu_hilo),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    // Behavioural MDU: latches op at the clock edge ending the issue cycle.
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    int unsigned   cnt;
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;

    assign prod_s   = $signed({{32{mdu_a[31]}}, mdu_a}) * $signed({{32{mdu_b[31]}}, mdu_b});
    assign prod_u   = {32'b0, mdu_a} * {32'b0, mdu_b};
    assign mdu_busy = (cnt != 0);
    assign mdu_hilo = (mdu_ctrl == OP_MFHI) ? hi : (mdu_ctrl == OP_MFLO) ? lo : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi  <= '0;
            lo  <= '0;
            cnt <= 0;
        end else begin
            if (cnt != 0) cnt <= cnt - 1;
            case (mdu_ctrl)
                OP_MTHI: hi <= mdu_a;
                OP_MTLO: lo <= mdu_a;
                OP_MULT:  if (mdu_start) begin {hi, lo} <= prod_s; cnt <= 5; end
                OP_MULTU: if (mdu_start) begin {hi, lo} <= prod_u; cnt <= 5; end
                OP_DIV: if (mdu_start) begin
                    if (mdu_b != 0) begin
                        lo <= $signed(mdu_a) / $signed(mdu_b);
                        hi <= $signed(mdu_a) % $signed(mdu_b);
                    end
                    cnt <= 10;
                end
                OP_DIVU: if (mdu_start) begin
                    if (mdu_b != 0) begin
                        lo <= mdu_a / mdu_b;
                        hi <= mdu_a % mdu_b;
                    end
                    cnt <= 10;
                end
                default: ;
            endcase
        end
    end

    // Issue one request on a port and follow it; lat is cycles from accept to resp_valid, -1 if none.
    task automatic do_req(input bit port, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int flush_cyc, output int lat,
                          output logic [31:0] data, output logic [3:0] ctrl1,
                          output logic start1, output logic busy2);
        bit acc;
        bit rv;
        acc = 1'b0;
        lat = -1; data = '0; ctrl1 = '1; start1 = 1'b1; busy2 = 1'b1;
        if (port) begin
            p1if.op = op; p1if.a = a; p1if.b = b; p1if.valid = 1'b1;
        end else begin
            p0if.op = op; p0if.a = a; p0if.b = b; p0if.valid = 1'b1;
        end
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = port ? p1if.ready : p0if.ready;
            @(posedge clk); #1;
        end
        p0if.valid = 1'b0;
        p1if.valid = 1'b0;
        if (acc) begin
            for (int n = 1; n <= 20; n++) begin
                flush = (n == flush_cyc);
                @(negedge clk);
                if (n == 1) begin ctrl1 = mdu_ctrl; start1 = mdu_start; end
                if (n == 2) busy2 = arb_busy;
                rv = port ? p1if.resp_valid : p0if.resp_valid;
                if (rv) begin
                    lat  = n;
                    data = port ? p1if.resp_data : p0if.resp_data;
                    if (port) p1if.resp_ready = 1'b1; else p0if.resp_ready = 1'b1;
                    flush = 1'b0;
                    @(posedge clk); #1;
                    p0if.resp_ready = 1'b0;
                    p1if.resp_ready = 1'b0;
                    break;
                end
                @(posedge clk); #1;
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        p0if.valid = 1'b1; p0if.op = OP_MFHI; p0if.a = '0; p0if.b = '0; p0if.resp_ready = 1'b0;
        p1if.valid = 1'b0; p1if.op = '0; p1if.a = '0; p1if.b = '0; p1if.resp_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (mdu_ctrl !== 4'd0 || mdu_start !== 1'b0 || arb_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mdu: ctrl=%0d start=%b busy=%b want 0 0 0", mdu_ctrl, mdu_start, arb_busy);
        end
        total++;
        if (p0if.ready !== 1'b0 || p0if.resp_valid !== 1'b0 || p1if.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ports: ready=%b rv0=%b rv1=%b want 0 0 0",
                     p0if.ready, p0if.resp_valid, p1if.resp_valid);
        end
        @(posedge clk); #1;
        p0if.valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int got[6];
        int n;
        bit both;
        int lat; logic [31:0] d; logic [3:0] c; logic s; logic bz;
        n = 0; both = 1'b0;
        for (int k = 0; k < 6; k++) got[k] = -1;
        p0if.op = OP_MTHI; p0if.a = 32'h11; p1if.op = OP_MTLO; p1if.a = 32'h22;
        p0if.resp_ready = 1'b1; p1if.resp_ready = 1'b1;
        p0if.valid = 1'b1; p1if.valid = 1'b1;
        for (int i = 0; i < 60 && n < 6; i++) begin
            @(negedge clk);
            if (p0if.ready && p1if.ready) both = 1'b1;
            if (p0if.ready) begin got[n] = 0; n++; end
            else if (p1if.ready) begin got[n] = 1; n++; end
            @(posedge clk); #1;
        end
        p0if.valid = 1'b0; p1if.valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        p0if.resp_ready = 1'b0; p1if.resp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (got[k] !== (k % 2)) begin
                bad++;
                $display("FAIL rr_grant%0d: got port %0d want port %0d", k, got[k], k % 2);
            end
        end
        total++;
        if (both) begin bad++; $display("FAIL rr_onehot: both ready got 1 want 0"); end
        do_req(1'b1, OP_MTLO, 32'h55, 32'h0, 0, lat, d, c, s, bz);
        do_req(1'b1, OP_MFLO, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 2 || d !== 32'h55) begin
            bad++;
            $display("FAIL rr_p1_mflo: lat=%0d data=%h want 2 00000055", lat, d);
        end
        do_req(1'b0, OP_MFHI, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'h11) begin bad++; $display("FAIL rr_p0_mfhi: data=%h want 00000011", d); end
    endtask

    task automatic test_multu();
        int lat; logic [31:0] d; logic [3:0] c; logic s; logic bz;
        do_req(1'b0, OP_MULTU, 32'd3, 32'd5, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 8 || c !== OP_MULTU || s !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL multu: lat=%0d ctrl=%0d start=%b data=%h want 8 6 1 0", lat, c, s, d);
        end
        do_req(1'b0, OP_MFLO, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 2 || c !== OP_MFLO || s !== 1'b0 || d !== 32'd15) begin
            bad++;
            $display("FAIL multu_mflo: lat=%0d ctrl=%0d start=%b data=%h want 2 2 0 0000000f", lat, c, s, d);
        end
        do_req(1'b0, OP_MFHI, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 2 || d !== 32'h0) begin
            bad++;
            $display("FAIL multu_mfhi: lat=%0d data=%h want 2 00000000", lat, d);
        end
    endtask

    task automatic test_div();
        int lat; logic [31:0] d; logic [3:0] c; logic s; logic bz;
        do_req(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 13 || c !== OP_DIV || s !== 1'b1) begin
            bad++;
            $display("FAIL div: lat=%0d ctrl=%0d start=%b want 13 7 1", lat, c, s);
        end
        do_req(1'b0, OP_MFHI, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_mfhi: data=%h want ffffffff", d); end
        do_req(1'b0, OP_MFLO, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_mflo: data=%h want fffffffd", d); end
    endtask

    task automatic test_invalid();
        int lat; logic [31:0] d; logic [3:0] c; logic s; logic bz;
        do_req(1'b0, 4'd9, 32'h1234, 32'h5678, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 2 || c !== 4'd0 || s !== 1'b0 || d !== 32'h0) begin
            bad++;
            $display("FAIL invalid9: lat=%0d ctrl=%0d start=%b data=%h want 2 0 0 0", lat, c, s, d);
        end
        do_req(1'b1, 4'd0, 32'h1, 32'h1, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 2 || c !== 4'd0 || s !== 1'b0) begin
            bad++;
            $display("FAIL invalid0: lat=%0d ctrl=%0d start=%b want 2 0 0", lat, c, s);
        end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] d; logic [3:0] c; logic s; logic bz;
        // flush in WAIT: committed op still answers
        do_req(1'b0, OP_MULT, 32'hFFFF_FFFD, 32'd4, 3, lat, d, c, s, bz);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL flush_wait: lat=%0d want 8", lat); end
        do_req(1'b0, OP_MFHI, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush_wait_hi: data=%h want ffffffff", d); end
        // flush in ISSUE: nothing reaches the MDU, no response
        do_req(1'b0, OP_MULT, 32'd2, 32'd3, 1, lat, d, c, s, bz);
        total++;
        if (lat !== -1 || c !== 4'd0 || s !== 1'b0 || bz !== 1'b0) begin
            bad++;
            $display("FAIL flush_issue: lat=%0d ctrl=%0d start=%b busy2=%b want -1 0 0 0", lat, c, s, bz);
        end
        do_req(1'b0, OP_MFLO, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'hFFFF_FFF4) begin bad++; $display("FAIL flush_issue_lo: data=%h want fffffff4", d); end
        // flush in DONE drops the response but the write already happened
        do_req(1'b0, OP_MTLO, 32'h77, 32'h0, 2, lat, d, c, s, bz);
        total++;
        if (lat !== -1 || bz !== 1'b1) begin
            bad++;
            $display("FAIL flush_done: lat=%0d busy2=%b want -1 1", lat, bz);
        end
        do_req(1'b0, OP_MFLO, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'h77) begin bad++; $display("FAIL flush_done_lo: data=%h want 00000077", d); end
        // flush never touches port 1
        do_req(1'b1, OP_MULT, 32'd7, 32'd6, 1, lat, d, c, s, bz);
        total++;
        if (lat !== 8 || c !== OP_MULT || s !== 1'b1) begin
            bad++;
            $display("FAIL flush_p1: lat=%0d ctrl=%0d start=%b want 8 5 1", lat, c, s);
        end
        do_req(1'b1, OP_MFLO, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'd42) begin bad++; $display("FAIL flush_p1_lo: data=%h want 0000002a", d); end
    endtask

    task automatic test_hold();
        int lat; logic [31:0] d; logic [3:0] c; logic s; logic bz;
        bit acc;
        acc = 1'b0;
        do_req(1'b1, OP_MTHI, 32'hA5A5_0001, 32'h0, 0, lat, d, c, s, bz);
        p1if.op = OP_MFHI; p1if.valid = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = p1if.ready;
            @(posedge clk); #1;
        end
        p1if.valid = 1'b0;
        total++;
        if (!acc) begin bad++; $display("FAIL hold_accept: ready got 0 want 1"); end
        p0if.op = OP_MFHI; p0if.valid = 1'b1;
        @(negedge clk);
        total++;
        if (p0if.ready !== 1'b0) begin bad++; $display("FAIL hold_issue_grant: ready=%b want 0", p0if.ready); end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (p1if.resp_valid !== 1'b1 || p1if.resp_data !== 32'hA5A5_0001 || p0if.ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stall%0d: rv=%b data=%h p0rdy=%b want 1 a5a50001 0",
                         k, p1if.resp_valid, p1if.resp_data, p0if.ready);
            end
            @(posedge clk); #1;
        end
        p1if.resp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (p1if.resp_valid !== 1'b1 || p0if.ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: rv=%b p0rdy=%b want 1 0", p1if.resp_valid, p0if.ready);
        end
        @(posedge clk); #1;
        p1if.resp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (p0if.ready !== 1'b1 || p1if.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_next_grant: p0rdy=%b rv1=%b want 1 0", p0if.ready, p1if.resp_valid);
        end
        @(posedge clk); #1;
        p0if.valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (p0if.resp_valid !== 1'b1 || p0if.resp_data !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL hold_p0_mfhi: rv=%b data=%h want 1 a5a50001", p0if.resp_valid, p0if.resp_data);
        end
        p0if.resp_ready = 1'b1;
        @(posedge clk); #1;
        p0if.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] d; logic [3:0] c; logic s; logic bz;
        bit acc;
        acc = 1'b0;
        p0if.op = OP_DIV; p0if.a = 32'd100; p0if.b = 32'd7; p0if.valid = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = p0if.ready;
            @(posedge clk); #1;
        end
        p0if.valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (!acc || arb_busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_wait: acc=%b busy=%b want 1 1", acc, arb_busy);
        end
        reset = 1'b0;
        p0if.op = OP_MFHI; p0if.valid = 1'b1;
        #1;
        total++;
        if (mdu_ctrl !== 4'd0 || mdu_start !== 1'b0 || arb_busy !== 1'b0 ||
            p0if.ready !== 1'b0 || p0if.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_outputs: ctrl=%0d start=%b busy=%b rdy=%b rv=%b want all 0",
                     mdu_ctrl, mdu_start, arb_busy, p0if.ready, p0if.resp_valid);
        end
        p0if.valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        do_req(1'b0, OP_MFHI, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (lat !== 2 || d !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_mfhi: lat=%0d data=%h want 2 00000000", lat, d);
        end
        do_req(1'b0, OP_MFLO, 32'h0, 32'h0, 0, lat, d, c, s, bz);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rstmid_mflo: data=%h want 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_multu();
        test_div();
        test_invalid();
        test_flush();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
